gate_truth_sequencer: RTL and testbench

- Self-checking controller that sequences a combinational logic gate such as the 2-input CMOS NOR.
- On start it walks every input vector, waits a settle time, samples the gate output and compares it against a parameterised truth table.
- Reports pass/fail, the error count and the first failing vector.
- Replaces free-running toggle stimulus with a synthesizable, repeatable check usable on-chip or in benches.

---
 rtl/gate_truth_sequencer_pkg.sv | 18 +
 rtl/gate_truth_sequencer_settle_timer.sv | 32 +++
 rtl/gate_truth_sequencer.sv | 118 +++++++++++
 tb/tb_gate_truth_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/gate_truth_sequencer_pkg.sv
// Shared definitions for the gate truth-table sequencer: state encoding and
// the width helper for the settle-time down-counter.
package gate_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Counter only ever holds SETTLE-1, so clog2(SETTLE) bits suffice;
    // keep at least one bit so SETTLE=1 still yields a legal vector.
    function automatic int cnt_width(input int settle);
        return (settle > 1) ? $clog2(settle) : 1;
    endfunction

endpackage

// File: rtl/gate_truth_sequencer_settle_timer.sv
// Loadable down-counter that times how long each input vector is held
// before the gate output is sampled. zero flags the final hold cycle.
module settle_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         clrn,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt;

    // Load takes priority over decrement; synchronous active-low clear.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking (<=) so every flop samples
        // pre-edge values regardless of statement order.
        if (!clrn)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec)
            cnt <= cnt - ONE;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/gate_truth_sequencer.sv
// Self-checking sequencer for a small combinational gate: walks every input
// vector, holds it for SETTLE cycles, samples dut_f and scores it against
// TRUTH. Reports pass, mismatch count and the first failing vector.
module gate_truth_sequencer
    import gate_seq_pkg::*;
#(
    parameter int                        N_IN   = 2,
    parameter int                        SETTLE = 2,
    parameter logic [(1 << N_IN) - 1:0]  TRUTH  = 'b0001
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic            start,
    input  logic            dut_f,
    output logic [N_IN-1:0] dut_in,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] fail_vec
);

    localparam int              CW          = cnt_width(SETTLE);
    localparam logic [CW-1:0]   SETTLE_LOAD = CW'(SETTLE - 1);
    localparam logic [N_IN-1:0] VEC_ONE     = N_IN'(1);
    localparam logic [N_IN:0]   ERR_ONE     = (N_IN + 1)'(1);

    state_t          state;
    logic [N_IN-1:0] vec;
    logic            timer_load;
    logic            timer_dec;
    logic            timer_zero;
    logic            mismatch;
    logic            last_vec;

    // dut_in is the registered vector, so it only moves on the edges that
    // leave IDLE or CHECK and never glitches between samples.
    assign dut_in   = vec;
    assign mismatch = (dut_f != TRUTH[vec]);
    assign last_vec = &vec;

    // Timer control: reload on entry to every WAIT, count down inside WAIT.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        timer_load = 1'b0;
        timer_dec  = 1'b0;
        case (state)
            S_IDLE:  timer_load = start;
            S_WAIT:  timer_dec  = !timer_zero;
            S_CHECK: timer_load = !last_vec;
            default: ;
        endcase
    end

    settle_timer #(
        .W (CW)
    ) u_settle_timer (
        .clk      (clk),
        .clrn     (clrn),
        .load     (timer_load),
        .dec      (timer_dec),
        .load_val (SETTLE_LOAD),
        .zero     (timer_zero)
    );

    // Sequencer FSM, vector counter and scoreboard with registered outputs.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state     <= S_IDLE;
            vec       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_WAIT;
                        vec       <= '0;
                        busy      <= 1'b1;
                        err_count <= '0;
                        fail_vec  <= '0;
                    end
                end
                S_WAIT: begin
                    if (timer_zero)
                        state <= S_CHECK;
                end
                S_CHECK: begin
                    if (mismatch) begin
                        err_count <= err_count + ERR_ONE;
                        if (err_count == '0)
                            fail_vec <= vec;
                    end
                    if (last_vec) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        // Fold in a mismatch found on this final sample.
                        pass  <= (err_count == '0) && !mismatch;
                    end else begin
                        state <= S_WAIT;
                        vec   <= vec + VEC_ONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_truth_sequencer.sv
// Bench for gate_truth_sequencer: a table of simulated gate behaviours is run
// through a default-parameter instance with results scored from a queue, then
// hand-written sequences cover start re-pulsing, mid-run reset and
// back-to-back runs on a SETTLE=1 instance.
module tb_gate_truth_sequencer;

    typedef struct {
        string      name;
        logic [3:0] gate;      // simulated gate: bit v = f for input vector v
        logic [2:0] exp_err;
        logic [1:0] exp_fail;
        logic       exp_pass;
    } tv_t;

    logic       clk = 1'b0;
    logic       clrn;
    int         cyc = 0;
    int         n_vec = 0;
    int         n_bad = 0;
    tv_t        tvs[5];
    tv_t        exp_q[$];

    // Instance A: defaults (N_IN=2, SETTLE=2, TRUTH=NOR)
    logic       start_a;
    logic [3:0] gate_a;
    logic       f_a;
    logic [1:0] in_a;
    logic       busy_a, done_a, pass_a;
    logic [2:0] err_a;
    logic [1:0] fv_a;

    // Instance B: SETTLE=1, driven by a good NOR
    logic       start_b;
    logic       f_b;
    logic [1:0] in_b;
    logic       busy_b, done_b, pass_b;
    logic [2:0] err_b;
    logic [1:0] fv_b;

    localparam logic [3:0] NOR_TT = 4'b0001;

    assign f_a = gate_a[in_a];
    assign f_b = NOR_TT[in_b];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gate_truth_sequencer u_dut_a (
        .clk       (clk),
        .clrn      (clrn),
        .start     (start_a),
        .dut_f     (f_a),
        .dut_in    (in_a),
        .busy      (busy_a),
        .done      (done_a),
        .pass      (pass_a),
        .err_count (err_a),
        .fail_vec  (fv_a)
    );

    gate_truth_sequencer #(
        .N_IN   (2),
        .SETTLE (1),
        .TRUTH  (4'b0001)
    ) u_dut_b (
        .clk       (clk),
        .clrn      (clrn),
        .start     (start_b),
        .dut_f     (f_b),
        .dut_in    (in_b),
        .busy      (busy_b),
        .done      (done_b),
        .pass      (pass_b),
        .err_count (err_b),
        .fail_vec  (fv_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One pulsed run on instance A; checks vector stepping, done timing and
    // scores the results against the queued expectation.
    task automatic run_a(input tv_t tv, input bit repulse);
        int   e0;
        int   d;
        int   n_done;
        logic prev_pass;
        tv_t  e;
        gate_a    = tv.gate;
        prev_pass = pass_a;
        exp_q.push_back(tv);
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        e0      = cyc;
        n_done  = 0;
        check({tv.name, "_busy"}, busy_a, 1'b1);
        for (d = 0; d < 30; d++) begin
            if (d < 12 && (d % 3) == 0)
                check({tv.name, "_dut_in"}, in_a, d / 3);
            if (d == 6)
                check({tv.name, "_pass_held"}, pass_a, prev_pass);
            if (done_a) begin
                n_done++;
                if (n_done == 1) begin
                    check({tv.name, "_done_cycle"}, d, 12);
                    if (exp_q.size() == 0) begin
                        check({tv.name, "_queue_empty"}, 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check({e.name, "_err_count"}, err_a, e.exp_err);
                        check({e.name, "_fail_vec"}, fv_a, e.exp_fail);
                        check({e.name, "_pass"}, pass_a, e.exp_pass);
                    end
                end
            end
            // Re-pulse start so it is sampled on edges E0+5 and E0+12.
            start_a = repulse && (d == 4 || d == 11);
            @(negedge clk);
            if (cyc - e0 != d + 1) check("cycle_track", cyc - e0, d + 1);
        end
        start_a = 1'b0;
        check({tv.name, "_done_pulses"}, n_done, 1);
        check({tv.name, "_idle_busy"}, busy_a, 1'b0);
    endtask

    initial begin
        int e0;
        int d;
        int n_done;
        int done_at[$];

        tvs[0] = '{"nor_good",   4'b0001, 3'd0, 2'd0, 1'b1};
        // NAND differs from NOR only at vectors 1 and 2 (both give 1 at 00,
        // both give 0 at 11), so two mismatches with vector 1 first.
        tvs[1] = '{"nand",       4'b0111, 3'd2, 2'd1, 1'b0};
        tvs[2] = '{"stuck0_v0",  4'b0000, 3'd1, 2'd0, 1'b0};
        tvs[3] = '{"all_wrong",  4'b1110, 3'd4, 2'd0, 1'b0};
        tvs[4] = '{"last_wrong", 4'b1001, 3'd1, 2'd3, 1'b0};

        clrn    = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        gate_a  = NOR_TT;
        repeat (3) @(negedge clk);
        check("rst_dut_in", in_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_pass", pass_a, 0);
        check("rst_err", err_a, 0);
        check("rst_fail_vec", fv_a, 0);
        clrn = 1'b1;

        for (int i = 0; i < 5; i++)
            run_a(tvs[i], 1'b0);

        // start pulses during the run must not disturb it
        run_a('{"repulse", NOR_TT, 3'd0, 2'd0, 1'b1}, 1'b1);

        // Mid-run reset on edge E0+7: everything clears, no done pulse.
        gate_a = 4'b0000;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (6) @(negedge clk);
        clrn = 1'b0;
        @(negedge clk);
        check("midrst_dut_in", in_a, 0);
        check("midrst_busy", busy_a, 0);
        check("midrst_done", done_a, 0);
        check("midrst_pass", pass_a, 0);
        check("midrst_err", err_a, 0);
        check("midrst_fail_vec", fv_a, 0);
        clrn   = 1'b1;
        n_done = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done_a) n_done++;
        end
        check("midrst_no_done", n_done, 0);
        run_a('{"after_rst", NOR_TT, 3'd0, 2'd0, 1'b1}, 1'b0);

        // SETTLE=1, start held high: first done after E0+8, one DONE cycle,
        // one IDLE cycle, second run accepted at E0+10, done after E0+18.
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        e0 = cyc;
        for (d = 0; d < 40; d++) begin
            if (done_b) begin
                done_at.push_back(d);
                check("b2b_pass", pass_b, 1);
                check("b2b_err", err_b, 0);
            end
            if (d == 9)  check("b2b_idle_busy", busy_b, 0);
            if (d == 10) check("b2b_rerun_busy", busy_b, 1);
            if (d == 4)  check("b2b_dut_in", in_b, 2);
            @(negedge clk);
        end
        start_b = 1'b0;
        if (done_at.size() < 2) begin
            check("b2b_done_count", done_at.size(), 2);
        end else begin
            check("b2b_first_done", done_at[0], 8);
            check("b2b_second_done", done_at[1], 18);
        end
        if (cyc - e0 != 40) check("b2b_cycle_track", cyc - e0, 40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
